// File: rtl/datapath.sv
// Phase-1 single-bus CPU datapath: sixteen GPRs, special registers, a priority
// bus mux and a combinational ALU, all sequenced by external one-hot strobes.
module datapath_reg #(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         clear,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clock) begin
    if (clear)   q <= '0;
    else if (en) q <= d;
  end
endmodule

module datapath #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic R0in,  R1in,  R2in,  R3in,  R4in,  R5in,  R6in,  R7in,
  input  logic R8in,  R9in,  R10in, R11in, R12in, R13in, R14in, R15in,
  input  logic HIin, LOin, PCin, IRin, Yin, Zin, MARin, MDRin,
  input  logic R0out,  R1out,  R2out,  R3out,  R4out,  R5out,  R6out,  R7out,
  input  logic R8out,  R9out,  R10out, R11out, R12out, R13out, R14out, R15out,
  input  logic HIout, LOout, Zhighout, Zlowout, PCout, MDRout, InPortout, Cout,
  input  logic IncPC, ADD, SUB, AND, OR, SHR, SHRA, SHL, ROR, ROL, NEG, NOT, MUL, DIV,
  input  logic             Read,
  input  logic [WIDTH-1:0] Mdatain,
  output logic [WIDTH-1:0] R0, R1, R2, R3, R4, R5, R6, R7,
  output logic [WIDTH-1:0] R8, R9, R10, R11, R12, R13, R14, R15,
  output logic [WIDTH-1:0] HI, LO, PC_out, IR, MAR, Y,
  output logic [2*WIDTH-1:0] Z,
  output logic [WIDTH-1:0] BusMuxOut_signal
);
  localparam int NREG = 16;
  localparam int SHW  = $clog2(WIDTH);

  logic [NREG-1:0]             rin, rout;
  logic [NREG-1:0][WIDTH-1:0]  gpr;
  logic [WIDTH-1:0]            bus, mdr_q, mdr_d;
  logic [2*WIDTH-1:0]          z_d;

  assign rin  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                 R7in,  R6in,  R5in,  R4in,  R3in,  R2in,  R1in, R0in};
  assign rout = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                 R7out,  R6out,  R5out,  R4out,  R3out,  R2out,  R1out, R0out};

  for (genvar i = 0; i < NREG; i++) begin : g_gpr
    datapath_reg #(.W(WIDTH)) u_gpr (
      .clock(clock), .clear(clear), .en(rin[i]), .d(bus), .q(gpr[i])
    );
  end

  assign mdr_d = Read ? Mdatain : bus;

  datapath_reg #(.W(WIDTH))   u_hi  (.clock(clock), .clear(clear), .en(HIin),  .d(bus),   .q(HI));
  datapath_reg #(.W(WIDTH))   u_lo  (.clock(clock), .clear(clear), .en(LOin),  .d(bus),   .q(LO));
  datapath_reg #(.W(WIDTH))   u_pc  (.clock(clock), .clear(clear), .en(PCin),  .d(bus),   .q(PC_out));
  datapath_reg #(.W(WIDTH))   u_ir  (.clock(clock), .clear(clear), .en(IRin),  .d(bus),   .q(IR));
  datapath_reg #(.W(WIDTH))   u_y   (.clock(clock), .clear(clear), .en(Yin),   .d(bus),   .q(Y));
  datapath_reg #(.W(WIDTH))   u_mar (.clock(clock), .clear(clear), .en(MARin), .d(bus),   .q(MAR));
  datapath_reg #(.W(WIDTH))   u_mdr (.clock(clock), .clear(clear), .en(MDRin), .d(mdr_d), .q(mdr_q));
  datapath_reg #(.W(2*WIDTH)) u_z   (.clock(clock), .clear(clear), .en(Zin),   .d(z_d),   .q(Z));

  // Lowest-numbered GPR wins; walking downward lets the lowest index write last.
  always_comb begin
    bus = '0;
    if (|rout) begin
      for (int i = NREG-1; i >= 0; i--)
        if (rout[i]) bus = gpr[i];
    end
    else if (HIout)     bus = HI;
    else if (LOout)     bus = LO;
    else if (Zhighout)  bus = Z[2*WIDTH-1:WIDTH];
    else if (Zlowout)   bus = Z[WIDTH-1:0];
    else if (PCout)     bus = PC_out;
    else if (MDRout)    bus = mdr_q;
    else if (InPortout) bus = '0;
    else if (Cout)      bus = {{(WIDTH-19){IR[18]}}, IR[18:0]};
  end

  assign BusMuxOut_signal = bus;

  // ALU: A = Y, B = bus
  logic [SHW-1:0]     sh;
  logic [SHW:0]       rsh;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   divisor, quot, rem;

  assign sh      = bus[SHW-1:0];
  assign rsh     = (SHW+1)'(WIDTH) - {1'b0, sh};
  assign prod    = $signed({{WIDTH{Y[WIDTH-1]}}, Y}) * $signed({{WIDTH{bus[WIDTH-1]}}, bus});
  assign divisor = (bus == '0) ? WIDTH'(1) : bus;
  assign quot    = $signed(Y) / $signed(divisor);
  assign rem     = $signed(Y) % $signed(divisor);

  always_comb begin
    z_d = '0;
    if      (IncPC) z_d[WIDTH-1:0] = bus + WIDTH'(1);
    else if (ADD)   z_d[WIDTH-1:0] = Y + bus;
    else if (SUB)   z_d[WIDTH-1:0] = Y - bus;
    else if (AND)   z_d[WIDTH-1:0] = Y & bus;
    else if (OR)    z_d[WIDTH-1:0] = Y | bus;
    else if (SHR)   z_d[WIDTH-1:0] = Y >> sh;
    else if (SHRA)  z_d[WIDTH-1:0] = $signed(Y) >>> sh;
    else if (SHL)   z_d[WIDTH-1:0] = Y << sh;
    else if (ROR)   z_d[WIDTH-1:0] = (Y >> sh) | (Y << rsh);
    else if (ROL)   z_d[WIDTH-1:0] = (Y << sh) | (Y >> rsh);
    else if (NEG)   z_d[WIDTH-1:0] = -bus;
    else if (NOT)   z_d[WIDTH-1:0] = ~bus;
    else if (MUL)   z_d            = prod;
    else if (DIV)   z_d            = (bus == '0) ? '0 : {rem, quot};
  end

  assign R0  = gpr[0];  assign R1  = gpr[1];  assign R2  = gpr[2];  assign R3  = gpr[3];
  assign R4  = gpr[4];  assign R5  = gpr[5];  assign R6  = gpr[6];  assign R7  = gpr[7];
  assign R8  = gpr[8];  assign R9  = gpr[9];  assign R10 = gpr[10]; assign R11 = gpr[11];
  assign R12 = gpr[12]; assign R13 = gpr[13]; assign R14 = gpr[14]; assign R15 = gpr[15];
endmodule

// File: tb/tb_datapath.sv
// Strobe-driven bench for the datapath; expected values are queued with the
// stimulus and compared after the clock edge that should produce them.
module tb_datapath;
  logic              clock = 0, clear = 0, rd = 0;
  logic [31:0]       mdatain = '0;
  logic [15:0]       rin = '0, rout = '0;
  logic [7:0]        isel = '0;  // HI LO PC IR Y Z MAR MDR (bit0..7)
  logic [7:0]        osel = '0;  // HI LO Zh Zl PC MDR InPort C
  logic [13:0]       ops  = '0;
  logic [15:0][31:0] r_q;
  logic [31:0]       hi, lo, pc, ir, mar, y, bus;
  logic [63:0]       z;

  localparam int I_HI=0, I_LO=1, I_PC=2, I_IR=3, I_Y=4, I_Z=5, I_MAR=6, I_MDR=7;
  localparam int O_HI=0, O_LO=1, O_ZH=2, O_ZL=3, O_PC=4, O_MDR=5, O_IN=6, O_C=7;
  localparam int OP_INC=0, OP_ADD=1, OP_SUB=2, OP_AND=3, OP_OR=4, OP_SHR=5, OP_SHRA=6,
                 OP_SHL=7, OP_ROR=8, OP_ROL=9, OP_NEG=10, OP_NOT=11, OP_MUL=12, OP_DIV=13;
  localparam int S_HI=16, S_LO=17, S_PC=18, S_IR=19, S_MAR=20, S_Y=21, S_Z=22, S_BUS=23;

  datapath dut (
    .clock(clock), .clear(clear),
    .R0in(rin[0]), .R1in(rin[1]), .R2in(rin[2]), .R3in(rin[3]), .R4in(rin[4]), .R5in(rin[5]),
    .R6in(rin[6]), .R7in(rin[7]), .R8in(rin[8]), .R9in(rin[9]), .R10in(rin[10]), .R11in(rin[11]),
    .R12in(rin[12]), .R13in(rin[13]), .R14in(rin[14]), .R15in(rin[15]),
    .HIin(isel[I_HI]), .LOin(isel[I_LO]), .PCin(isel[I_PC]), .IRin(isel[I_IR]),
    .Yin(isel[I_Y]), .Zin(isel[I_Z]), .MARin(isel[I_MAR]), .MDRin(isel[I_MDR]),
    .R0out(rout[0]), .R1out(rout[1]), .R2out(rout[2]), .R3out(rout[3]), .R4out(rout[4]),
    .R5out(rout[5]), .R6out(rout[6]), .R7out(rout[7]), .R8out(rout[8]), .R9out(rout[9]),
    .R10out(rout[10]), .R11out(rout[11]), .R12out(rout[12]), .R13out(rout[13]),
    .R14out(rout[14]), .R15out(rout[15]),
    .HIout(osel[O_HI]), .LOout(osel[O_LO]), .Zhighout(osel[O_ZH]), .Zlowout(osel[O_ZL]),
    .PCout(osel[O_PC]), .MDRout(osel[O_MDR]), .InPortout(osel[O_IN]), .Cout(osel[O_C]),
    .IncPC(ops[OP_INC]), .ADD(ops[OP_ADD]), .SUB(ops[OP_SUB]), .AND(ops[OP_AND]),
    .OR(ops[OP_OR]), .SHR(ops[OP_SHR]), .SHRA(ops[OP_SHRA]), .SHL(ops[OP_SHL]),
    .ROR(ops[OP_ROR]), .ROL(ops[OP_ROL]), .NEG(ops[OP_NEG]), .NOT(ops[OP_NOT]),
    .MUL(ops[OP_MUL]), .DIV(ops[OP_DIV]),
    .Read(rd), .Mdatain(mdatain),
    .R0(r_q[0]), .R1(r_q[1]), .R2(r_q[2]), .R3(r_q[3]), .R4(r_q[4]), .R5(r_q[5]),
    .R6(r_q[6]), .R7(r_q[7]), .R8(r_q[8]), .R9(r_q[9]), .R10(r_q[10]), .R11(r_q[11]),
    .R12(r_q[12]), .R13(r_q[13]), .R14(r_q[14]), .R15(r_q[15]),
    .HI(hi), .LO(lo), .PC_out(pc), .IR(ir), .MAR(mar), .Y(y), .Z(z),
    .BusMuxOut_signal(bus)
  );

  always #5 clock = ~clock;

  typedef struct { string tag; int sel; logic [63:0] exp; } sb_t;
  sb_t sb[$];
  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] obs(input int sel);
    if (sel < 16) return {32'h0, r_q[sel]};
    case (sel)
      S_HI:  return {32'h0, hi};
      S_LO:  return {32'h0, lo};
      S_PC:  return {32'h0, pc};
      S_IR:  return {32'h0, ir};
      S_MAR: return {32'h0, mar};
      S_Y:   return {32'h0, y};
      S_Z:   return z;
      default: return {32'h0, bus};
    endcase
  endfunction

  task automatic expect_q(input string tag, input int sel, input logic [63:0] exp);
    sb_t e;
    e.tag = tag; e.sel = sel; e.exp = exp;
    sb.push_back(e);
  endtask

  // One clock: apply the edge, drain the scoreboard with strobes still held, then idle.
  task automatic tick();
    sb_t e;
    @(posedge clock); #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.tag, obs(e.sel), e.exp);
    end
    rin = '0; rout = '0; isel = '0; osel = '0; ops = '0; rd = 0; clear = 0;
  endtask

  task automatic load_r(input int n, input logic [31:0] v);
    mdatain = v; rd = 1; isel[I_MDR] = 1; tick();
    osel[O_MDR] = 1; rin[n] = 1; tick();
  endtask

  // Y <- Ra; Z <- Y op Rb; expected Z queued for the ALU edge.
  task automatic alu(input string tag, input int op, input int ra, input int rb, input logic [63:0] exp);
    rout[ra] = 1; isel[I_Y] = 1; tick();
    rout[rb] = 1; ops[op] = 1; isel[I_Z] = 1;
    expect_q(tag, S_Z, exp);
    tick();
  endtask

  task automatic exec3(input string tag, input int op, input logic [31:0] exp);
    alu({tag, "_z"}, op, 5, 6, {32'h0, exp});
    osel[O_ZL] = 1; rin[2] = 1; expect_q(tag, 2, {32'h0, exp}); tick();
  endtask

  initial begin
    logic [31:0] a, b;
    clear = 1; tick();
    expect_q("rst_bus", S_BUS, 64'h0); expect_q("rst_z", S_Z, 64'h0);
    expect_q("rst_pc", S_PC, 64'h0); tick();

    // OR R2,R5,R6 with fetch
    load_r(5, 32'h34); load_r(6, 32'h45); load_r(2, 32'h67);
    osel[O_PC] = 1; ops[OP_INC] = 1; isel[I_MAR] = 1; isel[I_Z] = 1; tick();
    osel[O_ZL] = 1; isel[I_PC] = 1; rd = 1; isel[I_MDR] = 1; mdatain = 32'h112B0000; tick();
    osel[O_MDR] = 1; isel[I_IR] = 1;
    expect_q("pc", S_PC, 64'h1); expect_q("mar", S_MAR, 64'h0);
    expect_q("ir", S_IR, 64'h112B0000); tick();
    exec3("or", OP_OR, 32'h75);
    expect_q("r5", 5, 64'h34); expect_q("r6", 6, 64'h45); tick();
    osel[O_C] = 1; expect_q("c_sext", S_BUS, 64'h00030000); tick();
    exec3("add", OP_ADD, 32'h79);
    exec3("sub", OP_SUB, 32'hFFFFFFEF);
    exec3("and", OP_AND, 32'h04);

    // Bus priority: R-sources beat PC; lowest GPR index wins
    rout[6] = 1; rout[5] = 1; osel[O_PC] = 1; expect_q("bus_prio", S_BUS, 64'h34); tick();
    osel[O_IN] = 1; expect_q("inport", S_BUS, 64'h0); tick();

    // MUL -2 * 3
    load_r(1, 32'hFFFFFFFE); load_r(3, 32'h3);
    alu("mul", OP_MUL, 1, 3, 64'hFFFFFFFF_FFFFFFFA);
    osel[O_ZH] = 1; isel[I_HI] = 1; expect_q("hi", S_HI, 64'hFFFFFFFF); tick();
    osel[O_ZL] = 1; isel[I_LO] = 1; expect_q("lo", S_LO, 64'hFFFFFFFA); tick();

    // DIV
    load_r(1, 32'h11); load_r(3, 32'h5);
    alu("div", OP_DIV, 1, 3, {32'h2, 32'h3});
    load_r(1, 32'hFFFFFFEF);
    alu("div_neg", OP_DIV, 1, 3, {32'hFFFFFFFE, 32'hFFFFFFFD});
    load_r(3, 32'h0);
    alu("div_zero", OP_DIV, 1, 3, 64'h0);

    // Shifts and rotates
    load_r(1, 32'h80000001); load_r(3, 32'h1);
    alu("shr",  OP_SHR,  1, 3, 64'h40000000);
    alu("shra", OP_SHRA, 1, 3, 64'hC0000000);
    alu("shl",  OP_SHL,  1, 3, 64'h00000002);
    alu("ror",  OP_ROR,  1, 3, 64'hC0000000);
    alu("rol",  OP_ROL,  1, 3, 64'h00000003);
    load_r(3, 32'h0);
    alu("ror0", OP_ROR, 1, 3, 64'h80000001);

    // Random unary/binary checks
    for (int k = 0; k < 4; k++) begin
      a = $urandom(); b = $urandom();
      load_r(1, a); load_r(3, b);
      alu("add_rnd", OP_ADD, 1, 3, {32'h0, a + b});
      alu("neg_rnd", OP_NEG, 1, 3, {32'h0, 32'h0 - b});
      alu("not_rnd", OP_NOT, 1, 3, {32'h0, ~b});
    end

    // Same register as source and destination, with IncPC
    load_r(4, 32'h10);
    rout[4] = 1; ops[OP_INC] = 1; isel[I_Z] = 1; tick();
    osel[O_ZL] = 1; rin[4] = 1; expect_q("r4_inc", 4, 64'h11); tick();
    rout[4] = 1; rin[4] = 1; expect_q("r4_self", 4, 64'h11); tick();

    // Clear overrides loads
    load_r(3, 32'hDEAD); load_r(7, 32'h5);
    rout[7] = 1; isel[I_PC] = 1; tick();
    rout[3] = 1; ops[OP_NOT] = 1; isel[I_Z] = 1; tick();
    expect_q("pre_z", S_Z, {32'h0, ~32'hDEAD}); tick();
    clear = 1; rout[3] = 1; rin[3] = 1; isel = '1;
    expect_q("clr_r3", 3, 64'h0); expect_q("clr_pc", S_PC, 64'h0);
    expect_q("clr_z", S_Z, 64'h0); expect_q("clr_hi", S_HI, 64'h0);
    expect_q("clr_ir", S_IR, 64'h0); tick();
    expect_q("clr_bus", S_BUS, 64'h0); expect_q("clr_y", S_Y, 64'h0);
    expect_q("clr_lo", S_LO, 64'h0); expect_q("clr_mar", S_MAR, 64'h0);
    for (int i = 0; i < 16; i++) expect_q("clr_gpr", i, 64'h0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
